router_out_arbiter: RTL and testbench

//  Switch arbiter for one router output port. Shares the port among the five input FIFOs
//  (N,E,S,W,L heads) with round-robin fairness. Drives each FIFO's pop (fifo_ready_*) and

---
 rtl/router_out_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_router_out_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arbiter.sv
// router_out_arbiter
//   Switch arbiter for one router output port. The five input FIFO heads (N,E,S,W,L) compete
//   for the port with round-robin fairness. The arbiter pops the winning FIFO and forwards its
//   head flit to the neighbour's input sync FIFO in the same cycle.
//   Each router has five instances, one per output direction. Route computation happens
//   upstream, so req[i] already means "head valid and routed to this port".
//
//   Ports
//     clk       in   router clock; all state updates on the rising edge
//     rst_n     in   asynchronous active-low reset; all outputs are forced to 0 while low
//     req       in   per-input request (FIFO head valid and routed here)
//     data_in   in   packed head flits, input i at [i*DATASIZE +: DATASIZE]
//     out_full  in   downstream FIFO full; no write happens while high
//     rd_en     out  one-hot pop to the granted input FIFO (its rinc)
//     out_data  out  granted flit (downstream wdata)
//     out_valid out  write strobe to the downstream FIFO (its winc)
//     out_src   out  index of the granted input, 0 when out_valid=0
//
//   Build option
//     ARB_WORMHOLE_LOCK_EN: when defined, a packet whose first flit has tail=0 locks the port
//     to its input until the tail flit passes. When undefined, arbitration is per flit and
//     TAIL_BIT is ignored.

module router_out_arbiter #(
  parameter int unsigned NUM_IN   = 5,
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned TAIL_BIT = 39
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN*DATASIZE-1:0]   data_in,
  input  logic                         out_full,
  output logic [NUM_IN-1:0]            rd_en,
  output logic [DATASIZE-1:0]          out_data,
  output logic                         out_valid,
  output logic [2:0]                   out_src
);

  localparam int unsigned PtrW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef logic [PtrW-1:0] idx_t;

  localparam idx_t LastIdx = idx_t'(NUM_IN - 1);

  // Catch parameter sets that the fixed 3-bit out_src or the tail position cannot express.
  if (NUM_IN < 1 || NUM_IN > 8) begin : g_bad_num_in
    $error("router_out_arbiter: NUM_IN must be in 1..8 (out_src is 3 bits)");
  end
  if (TAIL_BIT >= DATASIZE) begin : g_bad_tail_bit
    $error("router_out_arbiter: TAIL_BIT must lie inside the flit");
  end

  // Next index in the ring, wrapping NUM_IN-1 -> 0.
  function automatic idx_t wrap_inc(idx_t i);
    return (i == LastIdx) ? '0 : i + idx_t'(1);
  endfunction

  // --------------------------------------------------------------------------------------------
  // Arbiter state
  // --------------------------------------------------------------------------------------------
  idx_t ptr_q;  // highest-priority input for the next grant

`ifdef ARB_WORMHOLE_LOCK_EN
  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e state_q;
  idx_t   owner_q;  // input that holds the port while in StLock
`endif

  // --------------------------------------------------------------------------------------------
  // Eligibility: in a locked packet only the owner may compete, and the others wait even if the
  // owner's FIFO has momentarily run dry.
  // --------------------------------------------------------------------------------------------
  logic [NUM_IN-1:0] eligible;

`ifdef ARB_WORMHOLE_LOCK_EN
  always_comb begin
    eligible = req;
    if (state_q == StLock) begin
      eligible = '0;
      eligible[owner_q] = req[owner_q];
    end
  end
`else
  assign eligible = req;
`endif

  // --------------------------------------------------------------------------------------------
  // Rotating priority search, starting at ptr_q and walking up the ring.
  // --------------------------------------------------------------------------------------------
  logic found;
  idx_t grant;
  idx_t scan;

  always_comb begin
    found = 1'b0;
    grant = ptr_q;
    scan  = ptr_q;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (!found && eligible[scan]) begin
        found = 1'b1;
        grant = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  // A transfer needs a winner and room downstream. rst_n is included so that the outputs are
  // silent during reset even though req may still be active.
  logic xfer;

  assign xfer = found & ~out_full & rst_n;

  // --------------------------------------------------------------------------------------------
  // Output mux. Pop and write are the same event, so they are asserted together or not at all.
  // --------------------------------------------------------------------------------------------
  always_comb begin
    rd_en     = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_src   = '0;
    if (xfer) begin
      rd_en[grant] = 1'b1;
      out_valid    = 1'b1;
      out_data     = data_in[grant*DATASIZE +: DATASIZE];
      out_src      = 3'(grant);
    end
  end

  // --------------------------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------------------------
`ifdef ARB_WORMHOLE_LOCK_EN
  logic tail;

  assign tail = data_in[grant*DATASIZE + TAIL_BIT];

  // Packet lock FSM. The pointer advances only when a packet completes, so the owner's
  // neighbour is next in line once the port is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      state_q <= StIdle;
      owner_q <= '0;
    end else if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (tail) begin
            // Single-flit packet: behave like plain round robin.
            ptr_q <= wrap_inc(grant);
          end else begin
            owner_q <= grant;
            state_q <= StLock;
          end
        end
        StLock: begin
          if (tail) begin
            ptr_q   <= wrap_inc(owner_q);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= wrap_inc(grant);
    end
  end
`endif

  // --------------------------------------------------------------------------------------------
  // Interface invariants
  // --------------------------------------------------------------------------------------------
  a_pop_matches_write : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid == (|rd_en));

  a_single_pop : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rd_en));

  a_no_write_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    out_full |-> !out_valid);

  a_pop_only_requester : assert property (@(posedge clk) disable iff (!rst_n)
    (rd_en & ~req) == '0);

endmodule

// File: tb/tb_router_out_arbiter.sv
module tb_router_out_arbiter;

  localparam int NumIn   = 5;
  localparam int Dw      = 40;
  localparam int TailBit = 39;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NumIn-1:0]      req;
  logic [NumIn*Dw-1:0]   data_in;
  logic                  out_full;
  logic [NumIn-1:0]      rd_en;
  logic [Dw-1:0]         out_data;
  logic                  out_valid;
  logic [2:0]            out_src;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_out_arbiter #(
    .NUM_IN  (NumIn),
    .DATASIZE(Dw),
    .TAIL_BIT(TailBit)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .out_full (out_full),
    .rd_en    (rd_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_src  (out_src)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------------------------
  // Reference model: the ring is a plain integer pointer, searched with modulo arithmetic.
  // Evaluated on the falling edge, when inputs are stable; the state it computes applies from
  // the next rising edge on.
  // ------------------------------------------------------------------------------------------
  int m_ptr   = 0;
  bit m_lock  = 1'b0;
  int m_owner = 0;

  always @(negedge clk) begin : compare
    logic [NumIn-1:0] elig;
    logic [NumIn-1:0] exp_rd;
    logic [Dw-1:0]    flit;
    int               g;
    bit               found;
    bit               xfer;
    if (!rst_n) begin
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_src", 64'(out_src), 64'd0);
      m_ptr   = 0;
      m_lock  = 1'b0;
      m_owner = 0;
    end else begin
      elig = req;
      if (m_lock) elig = req & (NumIn'(1) << m_owner);
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < NumIn; k++) begin
        if (!found && elig[(m_ptr + k) % NumIn]) begin
          found = 1'b1;
          g     = (m_ptr + k) % NumIn;
        end
      end
      xfer   = found && !out_full;
      flit   = data_in[g*Dw +: Dw];
      exp_rd = xfer ? (NumIn'(1) << g) : '0;
      chk("rd_en", 64'(rd_en), 64'(exp_rd));
      chk("out_valid", 64'(out_valid), 64'(xfer));
      chk("out_data", 64'(out_data), xfer ? 64'(flit) : 64'd0);
      chk("out_src", 64'(out_src), xfer ? 64'(g) : 64'd0);
      if (xfer) begin
`ifdef ARB_WORMHOLE_LOCK_EN
        if (!m_lock) begin
          if (flit[TailBit]) m_ptr = (g + 1) % NumIn;
          else begin
            m_lock  = 1'b1;
            m_owner = g;
          end
        end else if (flit[TailBit]) begin
          m_lock = 1'b0;
          m_ptr  = (m_owner + 1) % NumIn;
        end
`else
        m_ptr = (g + 1) % NumIn;
`endif
      end
    end
  end

  // ------------------------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------------------------
  task automatic set_flit(input int i, input logic tail);
    logic [Dw-1:0] f;
    f[31:0]  = $urandom;
    f[38:32] = 7'($urandom);
    f[39]    = tail;
    data_in[i*Dw +: Dw] = f;
  endtask

  task automatic all_tail(input logic tail);
    for (int i = 0; i < NumIn; i++) set_flit(i, tail);
  endtask

  // Leaves the bench 2 time units after a rising edge with reset released.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    req      = '0;
    out_full = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int seq2[6] = '{0, 1, 2, 3, 4, 0};
  int seq3[4] = '{0, 2, 0, 2};

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    data_in  = '0;
    out_full = 1'b0;

    // 1: reset holds all outputs at zero, even with every input requesting.
    @(negedge clk);
    chk("t1_rd_en_idle", 64'(rd_en), 64'd0);
    chk("t1_src_idle", 64'(out_src), 64'd0);
    req = 5'b11111;
    all_tail(1'b1);
    #1;
    chk("t1_rd_en_req", 64'(rd_en), 64'd0);
    chk("t1_valid_req", 64'(out_valid), 64'd0);
    chk("t1_data_req", 64'(out_data), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_valid_after_edge", 64'(out_valid), 64'd0);

    // 2: all requesting, single-flit packets: plain rotation.
    do_reset();
    all_tail(1'b1);
    req = 5'b11111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t2_src", 64'(out_src), 64'(seq2[c]));
      chk("t2_rd_en", 64'(rd_en), 64'(5'b00001 << seq2[c]));
      next_cycle();
    end

    // 3: downstream full blocks everything; arbitration resumes from the same pointer.
    do_reset();
    all_tail(1'b1);
    req      = 5'b00101;
    out_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_full_rd_en", 64'(rd_en), 64'd0);
      chk("t3_full_valid", 64'(out_valid), 64'd0);
      next_cycle();
    end
    out_full = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t3_src", 64'(out_src), 64'(seq3[c]));
      next_cycle();
    end

    // 4: a lone requester streams back to back.
    do_reset();
    req = 5'b10000;
    data_in[4*Dw +: Dw] = 40'hA5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_valid", 64'(out_valid), 64'd1);
      chk("t4_data", 64'(out_data), 64'hA5);
      chk("t4_rd_en", 64'(rd_en), 64'b10000);
      next_cycle();
    end

`ifdef ARB_WORMHOLE_LOCK_EN
    // 5: a three-flit packet from input 1 holds the port, including across a stall.
    do_reset();
    all_tail(1'b1);
    req = 5'b11111;
    @(negedge clk);
    chk("t5_first", 64'(out_src), 64'd0);
    next_cycle();
    set_flit(1, 1'b0);
    @(negedge clk);
    chk("t5_head", 64'(out_src), 64'd1);
    next_cycle();
    req = 5'b11101;
    @(negedge clk);
    chk("t5_stall_valid", 64'(out_valid), 64'd0);
    chk("t5_stall_rd_en", 64'(rd_en), 64'd0);
    next_cycle();
    req = 5'b11111;
    set_flit(1, 1'b0);
    @(negedge clk);
    chk("t5_body", 64'(out_src), 64'd1);
    next_cycle();
    set_flit(1, 1'b1);
    @(negedge clk);
    chk("t5_tail", 64'(out_src), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("t5_release", 64'(out_src), 64'd2);
    next_cycle();
`endif

    // 6: asynchronous reset mid-stream silences outputs at once; the ring restarts at 0.
    do_reset();
    set_flit(0, 1'b1);
    for (int i = 1; i < NumIn; i++) set_flit(i, 1'b0);
    req = 5'b11111;
    @(negedge clk);
    chk("t6_pre0", 64'(out_src), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t6_pre1", 64'(out_src), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_rd_en", 64'(rd_en), 64'd0);
    chk("t6_async_src", 64'(out_src), 64'd0);
    chk("t6_async_data", 64'(out_data), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart_src", 64'(out_src), 64'd0);
    chk("t6_restart_valid", 64'(out_valid), 64'd1);
    next_cycle();

    // Random traffic, back-pressure and occasional resets, checked by the model each cycle.
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 399) != 0);
      req      = NumIn'($urandom_range(0, 31));
      out_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NumIn; i++) set_flit(i, $urandom_range(0, 2) == 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
